// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add / restoring shift-subtract step per cycle on operand magnitudes.
module mdu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q_q, neg_q_d;
    logic                 neg_r_q, neg_r_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     ma_q, ma_d;
    logic [WIDTH-1:0]     mb_q, mb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    logic                 sa, sb;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_s;
    logic [WIDTH-1:0]     rem_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            a_q        <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            a_q        <= a_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done_d = (state_q == FIX);
    end

    always_comb begin
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        a_d        = a_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        sa        = op[0] & a[WIDTH-1];
        sb        = op[0] & b[WIDTH-1];
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : '0);
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mb_q};
        prod_s    = neg_q_q ? -acc_q : acc_q;
        quo_s     = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_s     = neg_r_q ? -rem_q : rem_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d      = '0;
                    is_div_d   = op[1];
                    neg_q_d    = sa ^ sb;
                    neg_r_d    = sa;
                    a_d        = a;
                    ma_d       = sa ? -a : a;
                    mb_d       = sb ? -b : b;
                    rem_d      = '0;
                    div_zero_d = 1'b0;
                    // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
                    acc_d      = {{WIDTH{1'b0}}, op[1] ? (sa ? -a : a) : (sb ? -b : b)};
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    rem_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
            end
            FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end else if (mb_q == '0) begin
                    hi_d       = a_q;
                    lo_d       = '1;
                    div_zero_d = 1'b1;
                end else begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end
            end
            default: ;
        endcase
    end

    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
